// File: rtl/branch_resolve_ctrl_if.sv
// Bus between the ID-stage pipeline logic and the branch resolve controller.
// Carries the decoded ID fields, the EX/MEM hazard sources, the comparator
// handshake (Zero in, Opcode/ALUControl out), the front-end control outputs
// and the statistics counters.
//   master : pipeline side (drives ID/EX/MEM fields, Kill, Zero)
//   slave  : controller side (drives comparator controls, stall/flush, stats)
interface branch_resolve_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ID_Valid;
    logic [5:0]       ID_Opcode;
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             EX_RegWrite;
    logic             EX_MemRead;
    logic [4:0]       EX_WriteReg;
    logic             MEM_RegWrite;
    logic             MEM_MemRead;
    logic [4:0]       MEM_WriteReg;
    logic             Kill;
    logic             Zero;
    logic [5:0]       CmpOpcode;
    logic [4:0]       CmpALUControl;
    logic             Stall;
    logic             ID_Flush;
    logic             PCSrc;
    logic             IF_Flush;
    logic [CNT_W-1:0] BrCount;
    logic [CNT_W-1:0] TakenCount;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output ID_Valid, ID_Opcode, ID_Rs, ID_Rt,
               EX_RegWrite, EX_MemRead, EX_WriteReg,
               MEM_RegWrite, MEM_MemRead, MEM_WriteReg,
               Kill, Zero,
        input  CmpOpcode, CmpALUControl, Stall, ID_Flush, PCSrc, IF_Flush,
               BrCount, TakenCount, StallCycles
    );

    modport slave (
        input  ID_Valid, ID_Opcode, ID_Rs, ID_Rt,
               EX_RegWrite, EX_MemRead, EX_WriteReg,
               MEM_RegWrite, MEM_MemRead, MEM_WriteReg,
               Kill, Zero,
        output CmpOpcode, CmpALUControl, Stall, ID_Flush, PCSrc, IF_Flush,
               BrCount, TakenCount, StallCycles
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolve controller for the five-stage MIPS pipeline.
// Decodes the branch in ID, computes the operand hazard depth against EX and
// MEM, stalls the front end for that many cycles, then drives the branch
// comparator and turns its Zero result into PCSrc / IF_Flush. Keeps
// saturating statistics counters (branches, taken branches, stall cycles).
// Ports:
//   Clk   : clock, all state on rising edge
//   Reset : synchronous active-low reset
//   bus   : branch_resolve_ctrl_if.slave (ID/EX/MEM fields, Kill, Zero in;
//           comparator controls, Stall/ID_Flush/PCSrc/IF_Flush, stats out)
// Control outputs are combinational from state and current inputs.
module branch_resolve_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    branch_resolve_ctrl_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE,
        STALL
    } state_t;

    state_t           state;
    logic [1:0]       cnt;
    logic [5:0]       op_q;
    logic [4:0]       alu_q;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic       is_beq, is_bne, is_bgtz, is_blez, is_bgez, is_bltz;
    logic       br_valid;
    logic       use_rt;
    logic [4:0] dec_alu;
    logic [1:0] depth;
    logic       resolve;
    logic       stall_c;
    logic [5:0] res_op;
    logic [4:0] res_alu;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] x,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       rt_used);
        return (x != 5'd0) && ((rs == x) || (rt_used && (rt == x)));
    endfunction

    always_comb begin
        is_beq   = (bus.ID_Opcode == 6'b000100);
        is_bne   = (bus.ID_Opcode == 6'b000101);
        is_bgtz  = (bus.ID_Opcode == 6'b000111);
        is_blez  = (bus.ID_Opcode == 6'b000110);
        is_bgez  = (bus.ID_Opcode == 6'b000001) && (bus.ID_Rt == 5'b00001);
        is_bltz  = (bus.ID_Opcode == 6'b000001) && (bus.ID_Rt == 5'b00000);
        br_valid = bus.ID_Valid &
                   (is_beq | is_bne | is_bgtz | is_blez | is_bgez | is_bltz);
        use_rt   = is_beq | is_bne;

        dec_alu = 5'b00000;
        if (is_bgez)      dec_alu = 5'b11000;
        else if (is_bltz) dec_alu = 5'b11001;

        // Load in EX needs two cycles; ALU result in EX or load in MEM needs one.
        depth = 2'd0;
        if (bus.EX_RegWrite && bus.EX_MemRead &&
            reg_match(bus.EX_WriteReg, bus.ID_Rs, bus.ID_Rt, use_rt))
            depth = 2'd2;
        else if ((bus.EX_RegWrite &&
                  reg_match(bus.EX_WriteReg, bus.ID_Rs, bus.ID_Rt, use_rt)) ||
                 (bus.MEM_RegWrite && bus.MEM_MemRead &&
                  reg_match(bus.MEM_WriteReg, bus.ID_Rs, bus.ID_Rt, use_rt)))
            depth = 2'd1;

        resolve = 1'b0;
        stall_c = 1'b0;
        res_op  = '0;
        res_alu = '0;
        if (Reset && !bus.Kill) begin
            if (state == IDLE) begin
                resolve = br_valid && (depth == 2'd0);
                stall_c = br_valid && (depth != 2'd0);
                res_op  = bus.ID_Opcode;
                res_alu = dec_alu;
            end else begin
                // ID is frozen while stalled; use the encoding captured on entry.
                resolve = (cnt == 2'd0);
                stall_c = (cnt != 2'd0);
                res_op  = op_q;
                res_alu = alu_q;
            end
        end
    end

    assign bus.CmpOpcode     = resolve ? res_op  : 6'b000000;
    assign bus.CmpALUControl = resolve ? res_alu : 5'b00000;
    assign bus.PCSrc         = resolve & bus.Zero;
    assign bus.IF_Flush      = resolve & bus.Zero;
    assign bus.Stall         = stall_c;
    assign bus.ID_Flush      = stall_c;
    assign bus.BrCount       = br_cnt;
    assign bus.TakenCount    = taken_cnt;
    assign bus.StallCycles   = stall_cnt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            alu_q     <= '0;
            br_cnt    <= '0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            // resolve/stall_c are already suppressed by Kill.
            if (resolve && (br_cnt != '1))
                br_cnt <= br_cnt + 1'b1;
            if (resolve && bus.Zero && (taken_cnt != '1))
                taken_cnt <= taken_cnt + 1'b1;
            if (stall_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;

            if (bus.Kill) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (br_valid && (depth != 2'd0)) begin
                            state <= STALL;
                            cnt   <= depth - 2'd1;
                            op_q  <= bus.ID_Opcode;
                            alu_q <= dec_alu;
                        end
                    end
                    STALL: begin
                        if (cnt != 2'd0)
                            cnt <= cnt - 2'd1;
                        else
                            state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: a cycle-by-cycle vector table
// plus hand-written kill/reset/saturation sequences, with a scoreboard queue.
module tb_branch_resolve_ctrl;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] BGTZ = 6'b000111;
    localparam logic [5:0] BLEZ = 6'b000110;
    localparam logic [5:0] RI   = 6'b000001;
    localparam logic [5:0] LW   = 6'b100011;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    branch_resolve_ctrl_if #(.CNT_W(16)) bus ();

    branch_resolve_ctrl #(.CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic       valid;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       ex_rw, ex_mr;
        logic [4:0] ex_wr;
        logic       mem_rw, mem_mr;
        logic [4:0] mem_wr;
        logic       kill, zero;
        logic [5:0] e_op;
        logic [4:0] e_alu;
        logic       e_stall, e_pc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [15:0] m_br, m_taken, m_stall;

    function automatic vec_t mk(
        input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
        input logic exrw, input logic exmr, input logic [4:0] exwr,
        input logic mrw, input logic mmr, input logic [4:0] mwr,
        input logic kill, input logic zero,
        input logic [5:0] eop, input logic [4:0] ealu, input logic est, input logic epc);
        vec_t r;
        r.valid = v; r.op = op; r.rs = rs; r.rt = rt;
        r.ex_rw = exrw; r.ex_mr = exmr; r.ex_wr = exwr;
        r.mem_rw = mrw; r.mem_mr = mmr; r.mem_wr = mwr;
        r.kill = kill; r.zero = zero;
        r.e_op = eop; r.e_alu = ealu; r.e_stall = est; r.e_pc = epc;
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        bus.ID_Valid     = v.valid;
        bus.ID_Opcode    = v.op;
        bus.ID_Rs        = v.rs;
        bus.ID_Rt        = v.rt;
        bus.EX_RegWrite  = v.ex_rw;
        bus.EX_MemRead   = v.ex_mr;
        bus.EX_WriteReg  = v.ex_wr;
        bus.MEM_RegWrite = v.mem_rw;
        bus.MEM_MemRead  = v.mem_mr;
        bus.MEM_WriteReg = v.mem_wr;
        bus.Kill         = v.kill;
        bus.Zero         = v.zero;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, ".BrCount"},     {16'd0, bus.BrCount},     {16'd0, m_br});
        chk({tag, ".TakenCount"},  {16'd0, bus.TakenCount},  {16'd0, m_taken});
        chk({tag, ".StallCycles"}, {16'd0, bus.StallCycles}, {16'd0, m_stall});
    endtask

    // One cycle: drive, push expectation, sample at negedge, pop and compare.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge Clk);
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".CmpOpcode"},     {26'd0, bus.CmpOpcode},     {26'd0, e.e_op});
            chk({tag, ".CmpALUControl"}, {27'd0, bus.CmpALUControl}, {27'd0, e.e_alu});
            chk({tag, ".Stall"},         {31'd0, bus.Stall},         {31'd0, e.e_stall});
            chk({tag, ".ID_Flush"},      {31'd0, bus.ID_Flush},      {31'd0, e.e_stall});
            chk({tag, ".PCSrc"},         {31'd0, bus.PCSrc},         {31'd0, e.e_pc});
            chk({tag, ".IF_Flush"},      {31'd0, bus.IF_Flush},      {31'd0, e.e_pc});
            // Every branch opcode is nonzero, so a nonzero expected opcode marks a resolve.
            if (e.e_op != 6'd0) m_br = sat_inc(m_br);
            if (e.e_pc)         m_taken = sat_inc(m_taken);
            if (e.e_stall)      m_stall = sat_inc(m_stall);
        end
        @(posedge Clk);
        #1;
        check_counters(tag);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        // Outputs must stay low during reset even with a resolvable taken branch.
        drive(mk(1, BEQ, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(negedge Clk);
        chk("rst.CmpOpcode", {26'd0, bus.CmpOpcode}, 32'd0);
        chk("rst.PCSrc",     {31'd0, bus.PCSrc},     32'd0);
        chk("rst.IF_Flush",  {31'd0, bus.IF_Flush},  32'd0);
        drive(mk(1, BNE, 5, 6, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst.Stall", {31'd0, bus.Stall}, 32'd0);
        @(posedge Clk);
        #1;
        m_br = '0; m_taken = '0; m_stall = '0;
        check_counters("rst");
        Reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t idle_v;
    vec_t v;

    initial begin
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        drive(idle_v);
        m_br = '0; m_taken = '0; m_stall = '0;

        // Consecutive-cycle table; rows after a stall are its continuation.
        //          v  op    rs rt exrw exmr exwr mrw mmr mwr kill z  eop   ealu      st pc
        tbl.push_back(mk(1, BEQ,  3, 4, 0, 0, 0,  0, 0, 0, 0, 1, BEQ,  5'b00000, 0, 1));
        tbl.push_back(mk(1, BEQ,  3, 4, 1, 0, 9,  0, 0, 0, 0, 0, BEQ,  5'b00000, 0, 0));
        tbl.push_back(mk(1, BNE,  5, 6, 0, 0, 0,  0, 0, 0, 0, 1, BNE,  5'b00000, 0, 1));
        tbl.push_back(mk(1, BGTZ, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, BGTZ, 5'b00000, 0, 0));
        tbl.push_back(mk(1, BLEZ, 2, 0, 0, 0, 0,  1, 0, 2, 0, 1, BLEZ, 5'b00000, 0, 1));
        tbl.push_back(mk(1, RI,   7, 1, 1, 0, 1,  0, 0, 0, 0, 1, RI,   5'b11000, 0, 1));
        tbl.push_back(mk(1, RI,   7, 0, 1, 1, 0,  0, 0, 0, 0, 0, RI,   5'b11001, 0, 0));
        tbl.push_back(mk(1, RI,   7, 2, 0, 0, 0,  0, 0, 0, 0, 1, 0,    5'b00000, 0, 0));
        tbl.push_back(mk(1, BEQ,  0, 0, 1, 1, 0,  1, 1, 0, 0, 1, BEQ,  5'b00000, 0, 1));
        tbl.push_back(mk(1, LW,   3, 4, 0, 0, 0,  0, 0, 0, 0, 1, 0,    5'b00000, 0, 0));
        tbl.push_back(mk(0, BEQ,  3, 4, 0, 0, 0,  0, 0, 0, 0, 1, 0,    5'b00000, 0, 0));
        // n=1 from EX ALU on rt; resolve row carries garbage ID inputs
        tbl.push_back(mk(1, BEQ,  3, 4, 1, 0, 4,  0, 0, 0, 0, 1, 0,    5'b00000, 1, 0));
        tbl.push_back(mk(0, LW,   9, 9, 1, 1, 9,  0, 0, 0, 0, 1, BEQ,  5'b00000, 0, 1));
        // bgez n=1 on rs
        tbl.push_back(mk(1, RI,   7, 1, 1, 0, 7,  0, 0, 0, 0, 0, 0,    5'b00000, 1, 0));
        tbl.push_back(mk(1, RI,   7, 1, 1, 0, 7,  0, 0, 0, 0, 0, RI,   5'b11000, 0, 0));
        // bne n=2 from EX load on rt
        tbl.push_back(mk(1, BNE,  5, 6, 1, 1, 6,  0, 0, 0, 0, 0, 0,    5'b00000, 1, 0));
        tbl.push_back(mk(1, BNE,  5, 6, 1, 1, 6,  0, 0, 0, 0, 0, 0,    5'b00000, 1, 0));
        tbl.push_back(mk(1, BNE,  5, 6, 1, 1, 6,  0, 0, 0, 0, 0, BNE,  5'b00000, 0, 0));
        // blez n=1 from MEM load
        tbl.push_back(mk(1, BLEZ, 8, 0, 0, 0, 0,  1, 1, 8, 0, 0, 0,    5'b00000, 1, 0));
        tbl.push_back(mk(1, BLEZ, 8, 0, 0, 0, 0,  1, 1, 8, 0, 1, BLEZ, 5'b00000, 0, 1));
        // EX load beats MEM load: n=2, then back-to-back branch with no dead cycle
        tbl.push_back(mk(1, BEQ,  3, 4, 1, 1, 3,  1, 1, 4, 0, 0, 0,    5'b00000, 1, 0));
        tbl.push_back(mk(1, BEQ,  3, 4, 1, 1, 3,  1, 1, 4, 0, 0, 0,    5'b00000, 1, 0));
        tbl.push_back(mk(1, BEQ,  3, 4, 1, 1, 3,  1, 1, 4, 0, 1, BEQ,  5'b00000, 0, 1));
        tbl.push_back(mk(1, BNE,  1, 2, 0, 0, 0,  0, 0, 0, 0, 1, BNE,  5'b00000, 0, 1));
        // Kill: no effect when idle, beats resolve, beats stall entry
        tbl.push_back(mk(0, BEQ,  3, 4, 0, 0, 0,  0, 0, 0, 1, 1, 0,    5'b00000, 0, 0));
        tbl.push_back(mk(1, BEQ,  3, 4, 0, 0, 0,  0, 0, 0, 1, 1, 0,    5'b00000, 0, 0));
        tbl.push_back(mk(1, BEQ,  3, 4, 1, 1, 3,  0, 0, 0, 1, 1, 0,    5'b00000, 0, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0,    5'b00000, 0, 0));

        @(posedge Clk);
        #1;
        do_reset();
        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Kill at T+1 of a two-cycle stall
        do_reset();
        v = mk(1, BNE, 5, 6, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        apply(v, "kill.T");
        v.kill = 1'b1; v.e_stall = 1'b0;
        apply(v, "kill.T1");
        apply(idle_v, "kill.T2");
        chk("kill.BrCount", {16'd0, bus.BrCount}, 32'd0);
        apply(mk(1, BEQ, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, BEQ, 0, 0, 1), "kill.next");

        // Reset at T+1 of a two-cycle stall, after one counted branch
        do_reset();
        apply(mk(1, BEQ, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, BEQ, 0, 0, 1), "rs.pre");
        apply(mk(1, BNE, 5, 6, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0, 1, 0), "rs.T");
        Reset = 1'b0;
        @(negedge Clk);
        chk("rs.T1.Stall",     {31'd0, bus.Stall},     32'd0);
        chk("rs.T1.ID_Flush",  {31'd0, bus.ID_Flush},  32'd0);
        chk("rs.T1.CmpOpcode", {26'd0, bus.CmpOpcode}, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        m_br = '0; m_taken = '0; m_stall = '0;
        chk("rs.T2.BrCount", {16'd0, bus.BrCount}, 32'd0);
        check_counters("rs.T2");
        apply(idle_v, "rs.idle");

        // Saturation: 65535 taken branches, then one more
        do_reset();
        drive(mk(1, BEQ, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        repeat (65535) @(posedge Clk);
        #1;
        m_br = 16'hFFFF; m_taken = 16'hFFFF; m_stall = 16'h0000;
        check_counters("sat.full");
        apply(mk(1, BEQ, 3, 4, 0, 0, 0, 0, 0, 0, 0, 1, BEQ, 0, 0, 1), "sat.extra");
        chk("sat.BrCount", {16'd0, bus.BrCount}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequences the ID-stage branch comparator (`ALU32BitBranch`) in the five-stage MIPS pipeline. It decodes the branch in ID and detects operand hazards against EX and MEM. It stalls the front end for the required number of cycles, then drives the comparator's `Opcode`/`ALUControl`, samples `Zero`, and issues `PCSrc` and the IF flush. It also keeps saturating branch-statistics counters for debug.

## Interface
- `CNT_W`, 16, width of each statistics counter
- `Clk`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-low reset; sampled on rising edge of `Clk`
- `ID_Valid`  in  1  ID stage holds a valid instruction
- `ID_Opcode`  in  6  instruction[31:26]
- `ID_Rs`, `ID_Rt`  in  5 each  instruction[25:21], [20:16]
- `EX_RegWrite`, `EX_MemRead`  in  1 each  EX-stage control
- `EX_WriteReg`  in  5  EX-stage destination register
- `MEM_RegWrite`, `MEM_MemRead`  in  1 each  MEM-stage control
- `MEM_WriteReg`  in  5  MEM-stage destination register
- `Kill`  in  1  abort any pending branch (external flush)
- `Zero`  in  1  comparator result
- `CmpOpcode`  out  6  to comparator `Opcode`
- `CmpALUControl`  out  5  to comparator `ALUControl`
- `Stall`  out  1  hold PC and IF/ID
- `ID_Flush`  out  1  insert bubble into ID/EX
- `PCSrc`  out  1  select branch target
- `IF_Flush`  out  1  squash IF/ID instruction
- `BrCount`, `TakenCount`, `StallCycles`  out  `CNT_W` each  statistics

## Operation
- Branch decode: `000100` beq, `000101` bne, `000111` bgtz, `000110` blez, `000001` REGIMM with `ID_Rt`=`00001` bgez or `00000` bltz. Any other REGIMM rt is not a branch.
- Comparator encoding: `CmpOpcode`=`ID_Opcode`. `CmpALUControl`=`11000` for bgez, `11001` for bltz, and `00000` otherwise.
- Operand use: all branches read rs. Only beq and bne read rt. Register 0 never matches.
- Hazard depth n, computed in IDLE only, with `match(x)` meaning rs or (rt if used) equals x:
  - n=2 if `EX_RegWrite & EX_MemRead & match(EX_WriteReg)`.
  - Otherwise n=1 if `EX_RegWrite & match(EX_WriteReg)`, or `MEM_RegWrite & MEM_MemRead & match(MEM_WriteReg)`.
  - Otherwise n=0.
- State machine, 2-bit counter `cnt`:
  - IDLE, no branch: all control outputs 0.
  - IDLE, branch with n=0: resolve this cycle.
  - IDLE, branch with n>0: `Stall`=1, `ID_Flush`=1, `cnt`←n−1, next state STALL.
  - STALL, `cnt`≠0: `Stall`=1, `ID_Flush`=1, `cnt`←`cnt`−1.
  - STALL, `cnt`=0: resolve this cycle, next state IDLE.
  - Inputs other than `Kill`, `Zero` and `Reset` are ignored in STALL, because ID is frozen.
- Resolve cycle:
  - `CmpOpcode`/`CmpALUControl` are driven as decoded.
  - `PCSrc`=`Zero`, `IF_Flush`=`Zero`, `Stall`=0.
  - `BrCount`+1; `TakenCount`+1 if `Zero`.
- Outside resolve cycles, `CmpOpcode`=`000000` and `CmpALUControl`=`00000`. `Zero` is never sampled outside a resolve cycle, since the comparator holds `Zero` on unlisted opcodes.
- `StallCycles` increments in each cycle with `Stall`=1.
- All counters saturate at all-ones and never wrap.
- `Kill`=1 in any state:
  - next state IDLE, `cnt`←0.
  - In that cycle `Stall`, `ID_Flush`, `PCSrc` and `IF_Flush` are forced to 0, and no counter increments.
  - `Kill` takes priority over a simultaneous resolve.
  - `Kill` with `ID_Valid`=0 has no effect beyond the above.

## Timing
- Reset (`Reset`=0 at an edge): state IDLE, `cnt`=0, all counters 0. This takes effect on the next edge only, not asynchronously.
- While `Reset` is low, all control outputs are 0 regardless of inputs. Reset during STALL abandons the branch without resolving it.
- All control outputs are combinational from state plus current inputs. Counters and state are registered.
- Branch in ID at cycle T:
  - n=0: resolves at T.
  - n=1: stalls at T, resolves at T+1.
  - n=2: stalls at T and T+1, resolves at T+2.
- Taken branch: `PCSrc` and `IF_Flush` are high for exactly the resolve cycle. The PC loads the target at the edge ending that cycle.
- Back-to-back branches: the branch entering ID the cycle after a resolve is evaluated normally from IDLE. There is no dead cycle.

## Test plan
- beq r3,r4 with no hazards and `Zero`=1 at T -> at T: `Stall`=0, `CmpOpcode`=`000100`, `PCSrc`=1, `IF_Flush`=1; `BrCount`=1, `TakenCount`=1.
- bne r5,r6 with EX lw writing r6 -> `Stall`=`ID_Flush`=1 at T and T+1; resolve at T+2 with `Zero`=0 -> `PCSrc`=0; `StallCycles`=2.
- bgez r7 (REGIMM, rt=`00001`) with EX add writing r7 -> 1 stall cycle; resolve at T+1 with `CmpALUControl`=`11000`. Repeat the same hazard on rt for bgez -> no stall, because rt is unused.
- Branch reading r0 with EX writing r0 -> no stall. REGIMM with rt=`00010` -> treated as non-branch, all outputs 0.
- `Kill` asserted at T+1 of a 2-cycle stall -> IDLE at T+2, no `PCSrc`, `BrCount` unchanged. Same test with `Reset` low at T+1 instead -> all counters 0 at T+2.
- Preload saturation by issuing 65535 taken branches -> next taken branch leaves `BrCount`=`TakenCount`=16'hFFFF.
